// File: rtl/mac_sequencer.sv
// mac_sequencer: clear / load / multiply / wait / accumulate sequencer for the MAC datapath,
// with abort, multiplier timeout and a sticky timeout error flag.
module mac_sequencer #(
    parameter int COUNT_W = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_macs,
    input  logic               abort,
    input  logic               end_mult,
    output logic               clr_acc,
    output logic               load_mult,
    output logic               begin_mult,
    output logic               add,
    output logic               write_en,
    output logic [COUNT_W-1:0] wr_addr,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [2:0]         state
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] ADD   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [2:0] ERROR = 3'd7;
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [COUNT_W-1:0] idx, n_lat;
    logic [WW-1:0]      wait_cnt;
    logic               terr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            n_lat    <= '0;
            wait_cnt <= '0;
            terr     <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_lat <= num_macs;
                    idx   <= '0;
                    terr  <= 1'b0;
                    state <= CLEAR;
                end
                CLEAR: state <= n_lat == '0 ? DONE : LOAD;
                LOAD:  state <= RUN;
                RUN: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                // a result arriving on the last allowed cycle still beats the timeout
                WAIT: if (end_mult) state <= ADD;
                      else if (TIMEOUT != 0 && wait_cnt == WLAST) state <= ERROR;
                      else wait_cnt <= wait_cnt + 1'b1;
                ADD: if (idx == n_lat - 1'b1) state <= DONE;
                     else begin
                         idx   <= idx + 1'b1;
                         state <= LOAD;
                     end
                ERROR: begin
                    terr  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clr_acc     = state == CLEAR;
    assign load_mult   = state == LOAD;
    assign begin_mult  = state == RUN;
    assign add         = state == ADD;
    assign write_en    = state == ADD;
    assign done        = state == DONE;
    assign busy        = state != IDLE;
    assign wr_addr     = idx;
    assign timeout_err = terr;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: builds each run's expected per-cycle state trace from the iteration
// recipe (N, per-iteration result latency, abort/reset point) and checks the DUT every cycle.
module tb_mac_sequencer;
    localparam int TO = 64;
    localparam logic [2:0] S_IDLE = 0, S_CLEAR = 1, S_LOAD = 2, S_RUN = 3, S_WAIT = 4,
                           S_ADD = 5, S_DONE = 6, S_ERROR = 7;

    logic clk = 0, rst, start, abort, end_mult;
    logic [7:0] num_macs;
    logic clr_acc, load_mult, begin_mult, add, write_en, busy, done, timeout_err;
    logic [7:0] wr_addr;
    logic [2:0] state;

    mac_sequencer #(.COUNT_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_macs(num_macs), .abort(abort),
        .end_mult(end_mult), .clr_acc(clr_acc), .load_mult(load_mult),
        .begin_mult(begin_mult), .add(add), .write_en(write_en), .wr_addr(wr_addr),
        .busy(busy), .done(done), .timeout_err(timeout_err), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int run_cyc = 0, done_at, err_at;
    logic [7:0] wr_log[$];
    logic [2:0] e_state;
    logic [7:0] e_addr, m_addr;
    logic e_terr, m_terr;
    bit e_valid = 0;

    task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, run_cyc, act, exp);
        end
    endtask

    always @(negedge clk) if (e_valid) begin
        chk("state", state, e_state);
        chk("clr_acc", clr_acc, e_state == S_CLEAR);
        chk("load_mult", load_mult, e_state == S_LOAD);
        chk("begin_mult", begin_mult, e_state == S_RUN);
        chk("add", add, e_state == S_ADD);
        chk("write_en", write_en, e_state == S_ADD);
        chk("done", done, e_state == S_DONE);
        chk("busy", busy, e_state != S_IDLE);
        chk("wr_addr", wr_addr, e_addr);
        chk("timeout_err", timeout_err, e_terr);
        if (write_en) wr_log.push_back(wr_addr);
        if (done) done_at = run_cyc;
        if (state == S_ERROR) err_at = run_cyc;
    end

    task step(input logic s, ab, r, em, input logic [7:0] nm,
              input logic [2:0] es, input logic [7:0] ea, input logic et);
        start = s; abort = ab; rst = r; end_mult = em; num_macs = nm;
        @(posedge clk); #1;
        run_cyc++;
        e_state = es; e_addr = ea; e_terr = et; e_valid = 1;
    endtask

    task idle();
        step(0, 0, 0, 0, 8'd0, S_IDLE, m_addr, m_terr);
    endtask

    task automatic run(input int n, input int ks[8], input int ab_iter, input int rst_at,
                       input bit noise);
        logic [2:0] sq[$];
        logic [7:0] aq[$];
        bit eq[$];
        bit err = 0, em, s;
        int ab_at = -1;
        logic [7:0] nm;
        sq.push_back(S_CLEAR); aq.push_back(0); eq.push_back(0);
        for (int i = 0; i < n && !err; i++) begin
            sq.push_back(S_LOAD); aq.push_back(8'(i)); eq.push_back(0);
            sq.push_back(S_RUN);  aq.push_back(8'(i)); eq.push_back(0);
            if (ks[i] < TO) begin
                for (int w = 0; w <= ks[i]; w++) begin
                    sq.push_back(S_WAIT); aq.push_back(8'(i)); eq.push_back(w == ks[i]);
                end
                sq.push_back(S_ADD); aq.push_back(8'(i)); eq.push_back(0);
            end else begin
                for (int w = 0; w < TO; w++) begin
                    sq.push_back(S_WAIT); aq.push_back(8'(i)); eq.push_back(0);
                end
                sq.push_back(S_ERROR); aq.push_back(8'(i)); eq.push_back(0);
                err = 1;
            end
        end
        if (!err) begin
            sq.push_back(S_DONE); aq.push_back(n > 0 ? 8'(n - 1) : 8'd0); eq.push_back(0);
        end
        for (int j = 0; j < sq.size(); j++)
            if (ab_iter >= 0 && ab_at < 0 && sq[j] == S_WAIT && aq[j] == 8'(ab_iter)) ab_at = j;
        wr_log.delete(); done_at = -1; err_at = -1; run_cyc = 0;
        step(1, 0, 0, 0, 8'(n), S_CLEAR, 8'd0, 1'b0);
        for (int j = 0; j < sq.size(); j++) begin
            em = sq[j] == S_WAIT ? eq[j] : (noise ? 1'($urandom) : 1'b0);
            s  = noise ? 1'($urandom) : 1'b0;
            nm = noise ? 8'($urandom) : 8'(n);
            if (j == rst_at) begin
                step(s, 0, 1, em, nm, S_IDLE, 8'd0, 1'b0);
                step(0, 0, 1, 0, nm, S_IDLE, 8'd0, 1'b0);
                m_addr = 0; m_terr = 0;
                return;
            end
            if (j == ab_at) begin
                step(s, 1, 0, em, nm, S_IDLE, aq[j], 1'b0);
                m_addr = aq[j]; m_terr = 0;
                return;
            end
            if (j + 1 < sq.size()) step(s, 0, 0, em, nm, sq[j+1], aq[j+1], 1'b0);
            else begin
                step(s, 0, 0, em, nm, S_IDLE, aq[j], err);
                m_addr = aq[j]; m_terr = err;
            end
        end
    endtask

    initial begin
        int ks[8];
        int n, ab;
        m_addr = 0; m_terr = 0;
        step(0, 0, 1, 0, 8'd0, S_IDLE, 8'd0, 1'b0);
        step(0, 0, 1, 0, 8'd0, S_IDLE, 8'd0, 1'b0);
        idle();
        // normal run: result in second WAIT cycle of every iteration
        run(3, '{1, 1, 1, 0, 0, 0, 0, 0}, -1, -1, 0);
        idle();
        chk("norm_done_cycle", done_at, 17);
        chk("norm_writes", wr_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("norm_addr", wr_log[i], i);
        run(0, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 0);
        idle();
        chk("n0_done_cycle", done_at, 2);
        chk("n0_writes", wr_log.size(), 0);
        run(2, '{100, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 0);
        idle();
        chk("to_error_cycle", err_at, 68);
        chk("to_no_done", done_at, -1);
        chk("to_flag", timeout_err, 1);
        run(1, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 0);
        idle();
        chk("to_flag_cleared", timeout_err, 0);
        run(4, '{1, 2, 1, 1, 0, 0, 0, 0}, 1, -1, 0);
        idle();
        chk("abort_no_done", done_at, -1);
        chk("abort_writes", wr_log.size(), 1);
        run(2, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, -1, 0);
        idle();
        chk("restart_addr", wr_log[0], 0);
        run(2, '{2, 2, 0, 0, 0, 0, 0, 0}, -1, -1, 1);
        idle();
        chk("ignored_writes", wr_log.size(), 2);
        chk("ignored_done_cycle", done_at, 14);
        run(5, '{1, 1, 1, 1, 1, 0, 0, 0}, -1, 8, 0);
        idle();
        chk("rst_writes", wr_log.size(), 1);
        chk("rst_addr", wr_addr, 0);
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) ks[i] = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 5);
            ab = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            run(n, ks, ab, -1, 1);
            idle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
